imem_loader: RTL
================

# imem_loader

Boot-time UART program loader sitting directly upstream of the pipelined core's instruction memory. While the core is held in reset, it receives a length-prefixed binary image over a serial line and writes it word by word into BRAM port A (the IMEM port). It then releases the core's active-low reset so fetch starts at PC 0 with the loaded image.

## Interface
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division), must be ≥ 4.
- MAX_WORDS, 1024, IMEM capacity in 32-bit words; larger images are rejected.
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset; one clock domain only.
- uart_rx  in  1  serial input, idle high, 8N1, LSB first; asynchronous to clk.
- wea  out  4  BRAM port A byte write enables; 4'hF for exactly one cycle per word, else 4'h0.
- addra  out  32  BRAM port A byte address = 4 × word index.
- dia  out  32  BRAM port A write data.
- core_rst_n  out  1  active-low reset to the core; low until the load completes.
- busy  out  1  high from the first accepted start bit until done or error.
- done  out  1  sticky; high after the last word is written.
- error  out  1  sticky; high on a bad length or a framing error.

## Operation
- uart_rx passes through a 2-flop synchronizer; only the synchronized value is used.
- RX byte FSM states and transitions:
  - IDLE: on sync_rx=0, go to START.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If the sample is 0, go to DATA. If it is 1 (false start), return to IDLE with no byte.
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first.
  - STOP: sample after CLKS_PER_BIT cycles. A 1 pulses byte_valid for one cycle. A 0 pulses frame_err.
- Byte assembly: word_sr <= {byte, word_sr[31:8]}. A 2-bit byte counter wraps 3→0; the 4th byte completes a word.
- Loader FSM states and transitions:
  - LEN: collect a 4-byte little-endian word count N. On completion: N==0 or N>MAX_WORDS goes to ERR, otherwise DATA.
  - DATA: collect 4 bytes, then go to WRITE.
  - WRITE: drive wea=4'hF, addra=idx<<2, dia=word_sr for one cycle, then idx++. If idx+1==N go to DONE, else DATA.
  - DONE: core_rst_n=1, done=1, busy=0; all further RX traffic is ignored.
  - ERR: error=1, busy=0, core_rst_n stays 0 until rst.
- frame_err in LEN or DATA goes to ERR. In DONE it is ignored.
- idx is clog2(MAX_WORDS+1) bits wide. The comparison with N is done at 32 bits, so N up to 2^32−1 is checked without overflow.

## Timing
- Reset values: wea=0, addra=0, dia=0, core_rst_n=0, busy=0, done=0, error=0. Both FSMs go to IDLE/LEN; idx, byte counter and word_sr are cleared.
- rst asserted mid-load aborts immediately, including during a WRITE cycle (wea=0 next cycle). A reload must resend the length header.
- byte_valid fires about 9.5 bit-times after the start edge, plus 2 synchronizer cycles.
- WRITE occurs in the cycle after the 4th byte's byte_valid. The write is 1 cycle wide and there is at most one write per 4 bytes.
- core_rst_n rises in the cycle after the final WRITE; done and busy change in the same cycle.
- addra and dia hold their last value outside WRITE; only wea qualifies a write.
- The loader never drives port B.

## Structure
- Shared package boot_pkg holds:
  - loader and RX state encodings;
  - HDR_BYTES=4;
  - the CLKS_PER_BIT derivation.
- Sub-module uart_rx (synchronizer + RX byte FSM). Outputs: byte[7:0], byte_valid, frame_err.
- imem_loader instantiates uart_rx and contains the loader FSM, word assembly and BRAM driving.
- At top level, core_rst_n ANDs with the board reset into the core's rst_n. The loader muxes BRAM port A with fetch: the loader owns port A while core_rst_n=0.

## Test plan
Benches use CLK_HZ=1_000_000, BAUD=100_000 (10 clks/bit), MAX_WORDS=16.
- Nominal load: send N=2 (02 00 00 00), then 13 05 00 00, then 93 00 10 00 → writes 32'h00000513 @0 and 32'h00100093 @4, each with wea=4'hF for 1 cycle; core_rst_n=1 and done=1 one cycle after the second write.
- Bad length: send N=0, and separately N=17 → error=1, no wea pulse, core_rst_n stays 0.
- Framing error: force the stop bit low during the 2nd data byte → error=1, no write issued.
- False start: a 3-cycle low glitch on uart_rx, then a valid load of N=1 → glitch ignored; a single write @0.
- Reset mid-load: assert rst after 6 of 12 bytes, then resend the full image → outputs return to reset values; exactly N writes are seen afterwards, starting at addra=0.
- Post-done traffic: after done, send 8 more bytes → no wea activity; core_rst_n stays 1.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the boot-time UART program loader:
// FSM encodings, header size and baud-rate divider derivation.
package boot_pkg;

    localparam int HDR_BYTES = 4;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [2:0] {
        LD_LEN,
        LD_DATA,
        LD_WRITE,
        LD_DONE,
        LD_ERR
    } ld_state_t;

    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// BRAM port A write bus driven by the loader into instruction memory.
interface imem_loader_if;
    logic [3:0]  wea;
    logic [31:0] addra;
    logic [31:0] dia;

    modport master (output wea, addra, dia);
    modport slave  (input  wea, addra, dia);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer plus mid-bit sampling byte FSM.
module uart_rx
    import boot_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       start_ok
);

    localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int CNT_W = $clog2(CPB);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CPB / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CPB - 1);

    logic             rx_meta;
    logic             sync_rx;
    rx_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_idx, bit_nxt;
    logic [7:0]       shreg, sh_nxt;
    logic             bv_nxt, fe_nxt, so_nxt;

    assign rx_byte = shreg;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        bit_nxt   = bit_idx;
        sh_nxt    = shreg;
        bv_nxt    = 1'b0;
        fe_nxt    = 1'b0;
        so_nxt    = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (!sync_rx) begin
                    state_nxt = RX_START;
                    cnt_nxt   = '0;
                end
            end
            RX_START: begin
                // A line that is high again at mid start bit was only a glitch.
                if (cnt == HALF_M1) begin
                    cnt_nxt = '0;
                    if (!sync_rx) begin
                        state_nxt = RX_DATA;
                        bit_nxt   = '0;
                        so_nxt    = 1'b1;
                    end else begin
                        state_nxt = RX_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt = '0;
                    sh_nxt  = {sync_rx, shreg[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = RX_STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RX_STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_nxt   = '0;
                    state_nxt = RX_IDLE;
                    bv_nxt    = sync_rx;
                    fe_nxt    = !sync_rx;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta    <= 1'b1;
            sync_rx    <= 1'b1;
            state      <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            start_ok   <= 1'b0;
        end else begin
            rx_meta    <= rx;
            sync_rx    <= rx_meta;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_idx    <= bit_nxt;
            shreg      <= sh_nxt;
            byte_valid <= bv_nxt;
            frame_err  <= fe_nxt;
            start_ok   <= so_nxt;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed image over UART, writes it into
// IMEM through BRAM port A, then releases the core's active-low reset.
module imem_loader
    import boot_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 115200,
    parameter int MAX_WORDS = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uart_rx,
    imem_loader_if.master bram,
    output logic          core_rst_n,
    output logic          busy,
    output logic          done,
    output logic          error
);

    localparam int IDX_W = $clog2(MAX_WORDS + 1);
    localparam logic [1:0] LAST_BYTE = 2'(HDR_BYTES - 1);

    logic [7:0]       rx_byte;
    logic             byte_valid;
    logic             frame_err;
    logic             start_ok;
    ld_state_t        state, state_nxt;
    logic [1:0]       byte_cnt;
    logic [31:0]      word_sr, word_nxt;
    logic [31:0]      len_q;
    logic [IDX_W-1:0] idx;
    logic [31:0]      idx_ext;
    logic             busy_q;
    logic             word_last;
    logic             collecting;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .rx         (uart_rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (frame_err),
        .start_ok   (start_ok)
    );

    assign word_nxt   = {rx_byte, word_sr[31:8]};
    assign word_last  = byte_valid && (byte_cnt == LAST_BYTE);
    assign idx_ext    = 32'(idx);
    assign collecting = (state == LD_LEN) || (state == LD_DATA);

    always_comb begin
        state_nxt = state;
        unique case (state)
            LD_LEN: begin
                if (frame_err) begin
                    state_nxt = LD_ERR;
                end else if (word_last) begin
                    if (word_nxt == 32'd0 || word_nxt > 32'(MAX_WORDS)) begin
                        state_nxt = LD_ERR;
                    end else begin
                        state_nxt = LD_DATA;
                    end
                end
            end
            LD_DATA: begin
                if (frame_err) begin
                    state_nxt = LD_ERR;
                end else if (word_last) begin
                    state_nxt = LD_WRITE;
                end
            end
            // Compared at 32 bits so a huge header can never alias a small idx.
            LD_WRITE: state_nxt = (idx_ext + 32'd1 == len_q) ? LD_DONE : LD_DATA;
            LD_DONE:  state_nxt = LD_DONE;
            LD_ERR:   state_nxt = LD_ERR;
            default:  state_nxt = LD_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= LD_LEN;
            byte_cnt   <= '0;
            word_sr    <= '0;
            len_q      <= '0;
            idx        <= '0;
            busy_q     <= 1'b0;
            bram.wea   <= 4'h0;
            bram.addra <= '0;
            bram.dia   <= '0;
        end else begin
            state    <= state_nxt;
            bram.wea <= (state_nxt == LD_WRITE) ? 4'hF : 4'h0;
            if (byte_valid && collecting) begin
                word_sr  <= word_nxt;
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (state == LD_LEN && state_nxt == LD_DATA) begin
                len_q <= word_nxt;
            end
            // Address and data are latched as the write starts and then held.
            if (state_nxt == LD_WRITE) begin
                bram.addra <= idx_ext << 2;
                bram.dia   <= word_nxt;
            end
            if (state == LD_WRITE) begin
                idx <= idx + IDX_W'(1);
            end
            if (start_ok && state != LD_DONE && state != LD_ERR) begin
                busy_q <= 1'b1;
            end
        end
    end

    always_comb begin
        core_rst_n = (state == LD_DONE);
        done       = (state == LD_DONE);
        error      = (state == LD_ERR);
        busy       = busy_q && (state == LD_LEN || state == LD_DATA || state == LD_WRITE);
    end

endmodule
